// File: rtl/adder4_pkg.sv
// Shared definitions for the adder_4 reduction controller.
// Holds the FSM state type and the adder_4 latency constant.
package adder4_pkg;

  localparam int ADDER4_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/adder4_reduce_ctrl_valid_pipe.sv
// Latency-matched valid shift register for beats in flight in adder_4.
// o_tail marks a beat whose sum is on add_out; o_any covers beats ahead of it.
module valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_tail,
  output logic o_any
);

  logic [DEPTH-1:0] r_pipe;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= i_in;
      end
      assign o_any = 1'b0;
    end else begin : g_many
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= {r_pipe[DEPTH-2:0], i_in};
      end
      assign o_any = |r_pipe[DEPTH-2:0];
    end
  endgenerate

  assign o_tail = r_pipe[DEPTH-1];

endmodule

// File: rtl/adder4_reduce_ctrl.sv
// Streams 4-word beats into an external adder_4 and accumulates the sums.
// Optional sticky carry flag ovf is enabled with ADDER4_REDUCE_OVF_EN.
module adder4_reduce_ctrl
  import adder4_pkg::*;
#(
  parameter int int_bits = 13,
  parameter int LEN_W    = 8,
  parameter int ADD_LAT  = ADDER4_LAT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [int_bits-1:0] in_d3,
  input  logic [int_bits-1:0] in_d2,
  input  logic [int_bits-1:0] in_d1,
  input  logic [int_bits-1:0] in_d0,
  output logic [int_bits-1:0] add_in3,
  output logic [int_bits-1:0] add_in2,
  output logic [int_bits-1:0] add_in1,
  output logic [int_bits-1:0] add_in0,
  input  logic [int_bits-1:0] add_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [int_bits-1:0] res_sum
`ifdef ADDER4_REDUCE_OVF_EN
  ,
  output logic                ovf
`endif
);

  state_t r_state, w_next;

  logic [LEN_W-1:0]    r_len, r_cnt;
  logic [int_bits-1:0] r_acc;
  logic w_start, w_accept, w_last, w_tail, w_ahead;

  assign w_start  = (r_state == IDLE) & start;
  assign w_accept = (r_state == FEED) & in_valid;
  assign w_last   = (r_cnt + LEN_W'(1)) == r_len;

  valid_pipe #(.DEPTH(ADD_LAT)) u_vpipe (
    .clk    (clk),
    .rst    (reset),
    .i_in   (w_accept),
    .o_tail (w_tail),
    .o_any  (w_ahead)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // DRAIN may exit while the tail sum lands: acc is final in DONE.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = (len == '0) ? DONE : FEED;
      end
      FEED: begin
        in_ready = 1'b1;
        if (w_accept && w_last) w_next = DRAIN;
      end
      DRAIN: begin
        if (!w_ahead) w_next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy    = (r_state != IDLE);
  assign add_in3 = w_accept ? in_d3 : '0;
  assign add_in2 = w_accept ? in_d2 : '0;
  assign add_in1 = w_accept ? in_d1 : '0;
  assign add_in0 = w_accept ? in_d0 : '0;
  assign res_sum = res_valid ? r_acc : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len <= '0;
      r_cnt <= '0;
    end else if (w_start) begin
      r_len <= len;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + LEN_W'(1);
    end
  end

`ifdef ADDER4_REDUCE_OVF_EN
  logic [int_bits:0] w_sum;
  logic              r_ovf;

  assign w_sum = {1'b0, r_acc} + {1'b0, add_out};
  assign ovf   = r_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_ovf <= 1'b0;
    else if (w_start)            r_ovf <= 1'b0;
    else if (w_tail && w_sum[int_bits]) r_ovf <= 1'b1;
  end
`else
  logic [int_bits-1:0] w_sum;

  assign w_sum = r_acc + add_out;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_acc <= '0;
    else if (w_start) r_acc <= '0;
    else if (w_tail)  r_acc <= w_sum[int_bits-1:0];
  end

endmodule

// File: tb/tb_adder4_reduce_ctrl.sv
// Scoreboard bench for adder4_reduce_ctrl with a 2-cycle adder_4 model.
// Directed jobs push expected sums; a monitor pops them on each result handshake.
module tb_adder4_reduce_ctrl;

  localparam int W = 13;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   len;
  logic         busy;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_d3, in_d2, in_d1, in_d0;
  logic [W-1:0] add_in3, add_in2, add_in1, add_in0;
  logic [W-1:0] add_out;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
`ifdef ADDER4_REDUCE_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;
  int unsigned exp_q[$];

  always #5 clk = ~clk;

  adder4_reduce_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_d3     (in_d3),
    .in_d2     (in_d2),
    .in_d1     (in_d1),
    .in_d0     (in_d0),
    .add_in3   (add_in3),
    .add_in2   (add_in2),
    .add_in1   (add_in1),
    .add_in0   (add_in0),
    .add_out   (add_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum)
`ifdef ADDER4_REDUCE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // adder_4 stand-in: two register stages, wraps modulo 2^W, no reset
  logic [W-1:0] r_s1, r_s2;
  always @(posedge clk) begin
    r_s1 <= add_in3 + add_in2 + add_in1 + add_in0;
    r_s2 <= r_s1;
  end
  assign add_out = r_s2;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    int unsigned e;
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_sum: unexpected result %0d, expected none", res_sum);
      end else begin
        e = exp_q.pop_front();
        chk("res_sum", res_sum, e);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int n, input int unsigned exp, input bit push);
    start = 1'b1;
    len   = 8'(n);
    if (push) exp_q.push_back(exp);
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic v, input int d3, input int d2,
                      input int d1, input int d0);
    longint e;
    in_valid = v;
    in_d3 = W'(d3);
    in_d2 = W'(d2);
    in_d1 = W'(d1);
    in_d0 = W'(d0);
    e = v ? {W'(d3), W'(d2), W'(d1), W'(d0)} : 0;
    @(negedge clk);
    chk("in_ready", in_ready, 1);
    chk("add_in", {add_in3, add_in2, add_in1, add_in0}, e);
    tick();
    in_valid = 1'b0;
  endtask

  // n counts cycles from the current one until res_valid is seen
  task automatic wait_res(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      n++;
      @(negedge clk);
      if (res_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) chk("res_valid_timeout", 0, 1);
  endtask

  int n;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_d3     = '0;
    in_d2     = '0;
    in_d1     = '0;
    in_d0     = '0;
    res_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_sum", res_sum, 0);
    chk("rst_add_in", {add_in3, add_in2, add_in1, add_in0}, 0);
    tick();
    reset = 1'b0;
    tick();

    // three back-to-back beats: 10+26+42
    start_job(3, 78, 1);
    beat(1, 1, 2, 3, 4);
    beat(1, 5, 6, 7, 8);
    beat(1, 9, 10, 11, 12);
    wait_res(n);
    chk("lat_len3", n, 3);
`ifdef ADDER4_REDUCE_OVF_EN
    chk("ovf_len3", ovf, 0);
`endif
    tick();
    @(negedge clk);
    chk("idle_after_len3", busy, 0);
    tick();

    // empty job
    start = 1'b1;
    len   = 8'd0;
    exp_q.push_back(0);
    @(negedge clk);
    chk("len0_in_ready", in_ready, 0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("len0_res_valid", res_valid, 1);
    chk("len0_in_ready_done", in_ready, 0);
    tick();
    tick();

    // gapped beats: add_in must stay zero while in_valid is low
    start_job(2, 800, 1);
    beat(1, 100, 100, 100, 100);
    in_d3 = 13'd100;
    in_d2 = 13'd100;
    in_d1 = 13'd100;
    in_d0 = 13'd100;
    repeat (2) begin
      @(negedge clk);
      chk("gap_add_in", {add_in3, add_in2, add_in1, add_in0}, 0);
      tick();
    end
    beat(1, 100, 100, 100, 100);
    wait_res(n);
    chk("lat_gap", n, 3);
    tick();
    tick();

    // wrap: 8188 + 8188 mod 8192
    start_job(2, 8184, 1);
    beat(1, 2047, 2047, 2047, 2047);
    beat(1, 2047, 2047, 2047, 2047);
    wait_res(n);
    chk("lat_wrap", n, 3);
`ifdef ADDER4_REDUCE_OVF_EN
    chk("ovf_wrap", ovf, 1);
`endif
    tick();
    tick();

    // back-pressure on result with start pulses ignored
    res_ready = 1'b0;
    start_job(1, 10, 1);
    beat(1, 1, 2, 3, 4);
    wait_res(n);
    chk("lat_hold", n, 3);
    tick();
    start = 1'b1;
    len   = 8'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_sum", res_sum, 10);
      chk("hold_busy", busy, 1);
      chk("hold_in_ready", in_ready, 0);
      tick();
    end
    start     = 1'b0;
    res_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("release_busy", busy, 0);
    chk("release_res_valid", res_valid, 0);
    tick();

    // reset during DRAIN with two beats in flight
    start_job(2, 0, 0);
    beat(1, 7, 7, 7, 7);
    beat(1, 7, 7, 7, 7);
    in_valid = 1'b1;
    in_d0    = 13'd5;
    reset    = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_res_sum", res_sum, 0);
    chk("abort_add_in", {add_in3, add_in2, add_in1, add_in0}, 0);
    tick();
    in_valid = 1'b0;
    reset    = 1'b0;
    start_job(1, 4, 1);
    beat(1, 1, 1, 1, 1);
    wait_res(n);
    chk("lat_after_abort", n, 3);
    tick();
    tick();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
